aes_enc_stream_ctrl: RTL
========================

Name: aes_enc_stream_ctrl

Overview:
Upstream/downstream wrapper around the AES-128 encryption core.
- Gathers 32-bit words from a valid/ready stream into 128-bit key and plaintext blocks.
- Drives the core's key_in/set_new_key/plain_text/start inputs.
- Waits the core's fixed pipeline latency, captures cipher_text, and emits it as four 32-bit words on a valid/ready output stream.
- Serialises work: one block in flight at a time.

Parameters:
ENC_LATENCY, 32, cycles from the edge sampling start=1 to the edge on which core cipher_text is valid; must match core; legal 2..255
CNT_W, 8, width of latency counter; must satisfy 2^CNT_W > ENC_LATENCY

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
s_data  input  32  input word
s_key  input  1  qualifies s_data: 1 = key word, 0 = plaintext word
s_valid  input  1  input word valid
s_ready  output  1  controller accepts input word
key_in  output  128  key to core
set_new_key  output  1  one-cycle pulse: core loads key_in
restart  output  1  tied 0
plain_text  output  128  plaintext block to core
start  output  1  one-cycle pulse: core begins encryption
cipher_text  input  128  core result
m_data  output  32  output word
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts output word
busy  output  1  high in any state other than COLLECT
drop  output  1  one-cycle pulse: plaintext block discarded (no key loaded)
err  output  1  one-cycle pulse: group broken by s_key change

Behaviour:
- Reset: state=COLLECT, word count=0, key_valid=0, key_in=0, plain_text=0, capture reg=0, all pulse outputs 0, m_valid=0, m_data=0.
- Transfer rules:
  - An input transfer occurs when s_valid & s_ready.
  - s_ready = 1 only in COLLECT.
  - An output transfer occurs when m_valid & m_ready.
- Word order: word 0 of a group goes to bits [127:96], word 3 to [31:0]. Output word 0 = cipher[127:96].
- Group type: the group takes its type from s_key of word 0.
  - If an accepted word 1..3 has a differing s_key, the partial group is discarded and err pulses.
  - That word becomes word 0 of a new group of its own type.

States:
- COLLECT
  - 4th key word accepted → KEY_LOAD.
  - 4th plaintext word accepted and key_valid=1 → START.
  - 4th plaintext word accepted and key_valid=0 → block discarded, drop pulses next cycle, stay in COLLECT, count=0.
- KEY_LOAD: set_new_key=1 for exactly this cycle; key_in already holds the new key; key_valid←1; → COLLECT.
- START: start=1 for exactly this cycle; plain_text stable; counter←ENC_LATENCY-1; → WAIT.
- WAIT: counter decrements each cycle. When counter==0, capture cipher_text on that edge → DRAIN.
  - Capture edge is exactly ENC_LATENCY cycles after the START edge.
- DRAIN:
  - m_valid=1, m_data = capture word[idx].
  - idx advances on each output transfer.
  - m_data/m_valid hold while m_ready=0.
  - After word 3 transfers: m_valid=0 next cycle, → COLLECT.

Stability and timing:
- key_in changes only during key collection; never while busy. plain_text holds from START until the next plaintext group completes.
- Back-to-back: the first s_ready of the next block is the cycle after the last output transfer. Minimum block period = 4 + 1 + ENC_LATENCY + 4 cycles.

Reset and edge cases:
- Reset asserted in any state (including mid-WAIT or mid-DRAIN) returns all reset values on the next edge. key_valid clears, so a new key is required.
- A key group arriving while a key is already valid replaces it; set_new_key pulses again.
- restart is held at 0.

Test Plan:
- FIPS-197 C.1 flow: key words 00010203,04050607,08090a0b,0c0d0e0f (s_key=1), then plaintext 00112233,44556677,8899aabb,ccddeeff. Bench core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after ENC_LATENCY. Required:
  - set_new_key one pulse, key_in = 000102…0f.
  - start one pulse, plain_text = 00112233…ff.
  - Output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a in order.
- Latency check: start pulse at cycle T → capture uses the cipher_text value present at T+32. Bench changes cipher_text at T+31 and T+33; only the T+32 value appears on m_data.
- Plaintext before any key after reset: 4 plaintext words → drop=1 for one cycle; start never asserts; s_ready stays 1.
- Group break: key words A,B then plaintext word C (s_key=0) → err pulse. Three further plaintext words complete a block starting with C; set_new_key does not pulse.
- Output backpressure: m_ready=0 for 10 cycles during DRAIN → m_data holds word 0 and s_ready=0. Then m_ready=1 → 4 words drain in 4 cycles; s_ready=1 the following cycle.
- Reset mid-WAIT: reset=1 for 1 cycle at WAIT cycle 5. Required: m_valid never asserts for that block; busy=0, s_ready=1 next cycle; the next plaintext block is dropped until a key is reloaded.

Source files
------------

// File: rtl/aes_enc_stream_ctrl_if.sv
// aes_enc_stream_ctrl_if: 32-bit input and output valid/ready word streams
interface aes_enc_stream_ctrl_if;
  logic [31:0] s_data;
  logic        s_key;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  modport master (output s_data, s_key, s_valid, m_ready, input s_ready, m_data, m_valid);
  modport slave  (input s_data, s_key, s_valid, m_ready, output s_ready, m_data, m_valid);
endinterface

// File: rtl/aes_enc_stream_ctrl.sv
// aes_enc_stream_ctrl: gathers key/plaintext words, runs the AES core, streams out the cipher words
module aes_enc_stream_ctrl #(
  parameter int ENC_LATENCY = 32,
  parameter int CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_enc_stream_ctrl_if.slave        io,
  output logic [127:0]                key_in,
  output logic                        set_new_key,
  output logic                        restart,
  output logic [127:0]                plain_text,
  output logic                        start,
  input  logic [127:0]                cipher_text,
  output logic                        busy,
  output logic                        drop,
  output logic                        err
);
  typedef enum logic [2:0] {COLLECT, KEY_LOAD, START, WAIT, DRAIN} state_t;
  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic         grp_q, grp_d, kv_q, kv_d, drop_q, drop_d, err_q, err_d;
  logic [95:0]  buf_q, buf_d;
  logic [127:0] key_q, key_d, pt_q, pt_d, cap_q, cap_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic         accept, brk;
  assign io.s_ready  = state_q == COLLECT;
  assign io.m_valid  = state_q == DRAIN;
  assign io.m_data   = state_q == DRAIN ? 32'(cap_q >> {~idx_q, 5'd0}) : 32'd0;
  assign accept      = io.s_valid && io.s_ready;
  assign brk         = cnt_q != 2'd0 && io.s_key != grp_q;
  assign key_in      = key_q;
  assign plain_text  = pt_q;
  assign set_new_key = state_q == KEY_LOAD;
  assign start       = state_q == START;
  assign restart     = 1'b0;
  assign busy        = state_q != COLLECT;
  assign drop        = drop_q;
  assign err         = err_q;
  // next state: word gathering, key/start sequencing, latency countdown and output drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    grp_d   = grp_q;
    kv_d    = kv_q;
    buf_d   = buf_q;
    key_d   = key_q;
    pt_d    = pt_q;
    cap_d   = cap_q;
    lat_d   = lat_q;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      COLLECT: if (accept) begin
        err_d = brk;
        grp_d = (cnt_q == 2'd0 || brk) ? io.s_key : grp_q;
        buf_d = {buf_q[63:0], io.s_data};
        cnt_d = brk ? 2'd1 : cnt_q + 2'd1;
        if (!brk && cnt_q == 2'd3) begin
          if (io.s_key) begin
            key_d   = {buf_q, io.s_data};
            state_d = KEY_LOAD;
          end else begin
            pt_d    = {buf_q, io.s_data};
            state_d = kv_q ? START : COLLECT;
            drop_d  = !kv_q;
          end
        end
      end
      KEY_LOAD: begin
        kv_d    = 1'b1;
        state_d = COLLECT;
      end
      START: begin
        lat_d   = CNT_W'(ENC_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d   = lat_q == '0 ? lat_q : lat_q - CNT_W'(1);
        cap_d   = lat_q == '0 ? cipher_text : cap_q;
        idx_d   = 2'd0;
        state_d = lat_q == '0 ? DRAIN : WAIT;
      end
      DRAIN: if (io.m_ready) begin
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? COLLECT : DRAIN;
      end
      default: state_d = COLLECT;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      grp_q   <= 1'b0;
      kv_q    <= 1'b0;
      buf_q   <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      cap_q   <= '0;
      lat_q   <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      grp_q   <= grp_d;
      kv_q    <= kv_d;
      buf_q   <= buf_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      cap_q   <= cap_d;
      lat_q   <= lat_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end
endmodule
